// File: rtl/pwm_driver_if.sv
// Operator-side signal bundle of the PWM driver: run request and speed buttons in,
// PWM drive, applied duty and status flags out.
interface pwm_driver_if #(
   parameter int DUTY_W = 8
);
   logic              motor_running;
   logic              btn_increase;
   logic              btn_decrease;
   logic              pwm_out;
   logic [DUTY_W-1:0] duty;
   logic              at_max;
   logic              at_min;
   logic              ramping;

   modport master (
      output motor_running, btn_increase, btn_decrease,
      input  pwm_out, duty, at_max, at_min, ramping
   );

   modport slave (
      input  motor_running, btn_increase, btn_decrease,
      output pwm_out, duty, at_max, at_min, ramping
   );
endinterface

// File: rtl/pwm_driver.sv
// Fixed-period PWM generator with a button-stepped duty setpoint and a
// soft-start/soft-stop ramp limiting the applied duty change per period.
module pwm_driver #(
   parameter int DUTY_W    = 8,
   parameter int PERIOD    = 100,
   parameter int STEP      = 10,
   parameter int DUTY_INIT = 50
) (
   input  logic       clk,
   input  logic       rst,
   pwm_driver_if.slave bus
);
   typedef enum logic [1:0] {
      ST_OFF       = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RUN       = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } state_e;

   localparam logic [DUTY_W:0]   PERIOD_W = (DUTY_W+1)'(PERIOD);
   localparam logic [DUTY_W:0]   STEP_W   = (DUTY_W+1)'(STEP);
   localparam logic [DUTY_W-1:0] PERIOD_N = DUTY_W'(PERIOD);
   localparam logic [DUTY_W-1:0] LAST_N   = DUTY_W'(PERIOD - 1);
   localparam logic [DUTY_W-1:0] INIT_N   = DUTY_W'(DUTY_INIT);
   localparam logic [DUTY_W-1:0] ZERO_N   = {DUTY_W{1'b0}};

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] cnt_q, cnt_d;
   logic [DUTY_W-1:0] duty_set_q, duty_set_d;
   logic [DUTY_W-1:0] duty_eff_q, duty_eff_d;
   logic              pwm_q, pwm_d;
   logic              inc_prev_q, dec_prev_q;

   logic              inc_pulse_s, dec_pulse_s, pend_s;
   logic [DUTY_W:0]   set_up_s, set_dn_s, eff_up_s, eff_dn_s;
   logic [DUTY_W-1:0] eff_up_sat_s, eff_dn_sat_s;

   // Next-state logic: setpoint saturation, counter, ramp FSM and PWM compare
   always_comb begin
      inc_pulse_s = bus.btn_increase & ~inc_prev_q;
      dec_pulse_s = bus.btn_decrease & ~dec_prev_q;
      pend_s      = (state_q != ST_OFF) && (cnt_q == LAST_N);

      // One bit of headroom keeps the saturating add/subtract from wrapping
      set_up_s = {1'b0, duty_set_q} + STEP_W;
      set_dn_s = {1'b0, duty_set_q} - STEP_W;
      eff_up_s = {1'b0, duty_eff_q} + STEP_W;
      eff_dn_s = {1'b0, duty_eff_q} - STEP_W;

      if (inc_pulse_s && !dec_pulse_s) begin
         duty_set_d = (set_up_s > PERIOD_W) ? PERIOD_N : set_up_s[DUTY_W-1:0];
      end else if (dec_pulse_s && !inc_pulse_s) begin
         duty_set_d = ({1'b0, duty_set_q} < STEP_W) ? ZERO_N : set_dn_s[DUTY_W-1:0];
      end else begin
         duty_set_d = duty_set_q;
      end

      eff_up_sat_s = (eff_up_s > {1'b0, duty_set_q}) ? duty_set_q : eff_up_s[DUTY_W-1:0];
      eff_dn_sat_s = ({1'b0, duty_eff_q} < STEP_W) ? ZERO_N : eff_dn_s[DUTY_W-1:0];

      if (state_q == ST_OFF) begin
         cnt_d = ZERO_N;
      end else if (cnt_q == LAST_N) begin
         cnt_d = ZERO_N;
      end else begin
         cnt_d = cnt_q + {{(DUTY_W-1){1'b0}}, 1'b1};
      end

      pwm_d      = (state_q != ST_OFF) && (cnt_q < duty_eff_q);
      state_d    = state_q;
      duty_eff_d = duty_eff_q;

      case (state_q)
         ST_OFF: begin
            if (bus.motor_running) begin
               state_d = ST_RAMP_UP;
            end else begin
               state_d = ST_OFF;
            end
         end
         ST_RAMP_UP: begin
            if (!bus.motor_running) begin
               state_d = ST_RAMP_DOWN;
            end else if (pend_s && (duty_set_q <= duty_eff_q)) begin
               duty_eff_d = duty_set_q;
               state_d    = ST_RUN;
            end else if (pend_s) begin
               duty_eff_d = eff_up_sat_s;
               state_d    = (eff_up_sat_s == duty_set_q) ? ST_RUN : ST_RAMP_UP;
            end else begin
               state_d = ST_RAMP_UP;
            end
         end
         ST_RUN: begin
            if (!bus.motor_running) begin
               state_d = ST_RAMP_DOWN;
            end else if (pend_s) begin
               duty_eff_d = duty_set_q;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RAMP_DOWN: begin
            if (bus.motor_running) begin
               state_d = ST_RAMP_UP;
            end else if (pend_s) begin
               duty_eff_d = eff_dn_sat_s;
               state_d    = (eff_dn_sat_s == ZERO_N) ? ST_OFF : ST_RAMP_DOWN;
            end else begin
               state_d = ST_RAMP_DOWN;
            end
         end
         default: begin
            state_d    = ST_OFF;
            duty_eff_d = ZERO_N;
         end
      endcase
   end

   // State, counter, setpoint, applied duty, PWM and button-history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_OFF;
         cnt_q      <= ZERO_N;
         duty_set_q <= INIT_N;
         duty_eff_q <= ZERO_N;
         pwm_q      <= 1'b0;
         inc_prev_q <= 1'b0;
         dec_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         duty_set_q <= duty_set_d;
         duty_eff_q <= duty_eff_d;
         pwm_q      <= pwm_d;
         inc_prev_q <= bus.btn_increase;
         dec_prev_q <= bus.btn_decrease;
      end
   end

   assign bus.pwm_out = pwm_q;
   assign bus.duty    = duty_eff_q;
   assign bus.at_max  = (duty_set_q == PERIOD_N);
   assign bus.at_min  = (duty_set_q == ZERO_N);
   assign bus.ramping = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
endmodule

// File: tb/tb_pwm_driver.sv
// Scoreboard bench for pwm_driver: a cycle model predicts every output vector,
// which is queued at drive time and compared after the following clock edge.
module tb_pwm_driver;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pwm_driver_if #(.DUTY_W(8)) pif ();

   pwm_driver #(.DUTY_W(8), .PERIOD(100), .STEP(10), .DUTY_INIT(50)) dut (
      .clk (clk),
      .rst (rst),
      .bus (pif.slave)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic mr_v = 1'b0, bi_v = 1'b0, bd_v = 1'b0, rst_v = 1'b1;

   // Reference model state: 0 OFF, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
   int m_state, m_cnt, m_set, m_eff;
   bit m_pwm, m_pi, m_pd;

   logic [11:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_set = 50; m_eff = 0;
      m_pwm = 1'b0; m_pi = 1'b0; m_pd = 1'b0;
   endtask

   task automatic model_step(input bit mr, input bit bi, input bit bd);
      bit ip, dp, pend;
      int n_set, n_eff, n_state, n_cnt;
      ip = bi && !m_pi;
      dp = bd && !m_pd;
      n_set = m_set;
      if (ip && !dp) n_set = (m_set + 10 > 100) ? 100 : m_set + 10;
      if (dp && !ip) n_set = (m_set - 10 < 0) ? 0 : m_set - 10;
      pend  = (m_state != 0) && (m_cnt == 99);
      n_cnt = (m_state == 0) ? 0 : (m_cnt + 1) % 100;
      n_eff = m_eff;
      n_state = m_state;
      if (m_state == 0) begin
         if (mr) n_state = 1;
      end else if (m_state == 1) begin
         if (!mr) n_state = 3;
         else if (pend) begin
            n_eff = (m_eff + 10 < m_set) ? m_eff + 10 : m_set;
            if (n_eff == m_set) n_state = 2;
         end
      end else if (m_state == 2) begin
         if (!mr) n_state = 3;
         else if (pend) n_eff = m_set;
      end else begin
         if (mr) n_state = 1;
         else if (pend) begin
            n_eff = (m_eff > 10) ? m_eff - 10 : 0;
            if (n_eff == 0) n_state = 0;
         end
      end
      m_pwm = (m_state != 0) && (m_cnt < m_eff);
      m_state = n_state; m_cnt = n_cnt; m_set = n_set; m_eff = n_eff;
      m_pi = bi; m_pd = bd;
   endtask

   function automatic logic [11:0] model_out();
      logic [7:0] d;
      d = 8'(m_eff);
      return {m_pwm, d, m_set == 100, m_set == 0, (m_state == 1) || (m_state == 3)};
   endfunction

   function automatic logic [11:0] dut_out();
      return {pif.pwm_out, pif.duty, pif.at_max, pif.at_min, pif.ramping};
   endfunction

   task automatic cycle();
      @(negedge clk);
      rst = rst_v;
      pif.motor_running = mr_v;
      pif.btn_increase  = bi_v;
      pif.btn_decrease  = bd_v;
      if (rst_v) model_reset();
      else model_step(mr_v, bi_v, bd_v);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      check_eq("cyc", 32'(dut_out()), 32'(exp_q.pop_front()));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_state(input int target, input int limit, input string tag);
      int i;
      for (i = 0; i < limit && m_state != target; i++) cycle();
      check_eq(tag, 32'(i < limit), 32'd1);
   endtask

   task automatic press(input bit inc, input int n);
      for (int k = 0; k < n; k++) begin
         if (inc) bi_v = 1'b1; else bd_v = 1'b1;
         run(5);
         bi_v = 1'b0; bd_v = 1'b0;
         run(5);
      end
   endtask

   task automatic count_high(input int expect_hi, input string tag);
      int hi;
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         hi += int'(pif.pwm_out);
      end
      check_eq(tag, 32'(hi), 32'(expect_hi));
   endtask

   initial begin
      int i;
      rst = 1'b1;
      pif.motor_running = 1'b0;
      pif.btn_increase  = 1'b0;
      pif.btn_decrease  = 1'b0;
      model_reset();
      run(2);
      check_eq("rst_out", 32'(dut_out()), 32'h000);
      rst_v = 1'b0;

      // Idle with the motor off
      run(300);
      check_eq("idle_pwm", 32'(pif.pwm_out), 32'd0);
      check_eq("idle_duty", 32'(pif.duty), 32'd0);

      // Soft start to the initial setpoint
      mr_v = 1'b1;
      wait_state(2, 800, "ramp_to_run");
      check_eq("run_duty", 32'(pif.duty), 32'd50);
      check_eq("run_ramping", 32'(pif.ramping), 32'd0);
      count_high(50, "hi_50");

      // Saturate the setpoint upward
      press(1'b1, 6);
      check_eq("at_max", 32'(pif.at_max), 32'd1);
      run(200);
      check_eq("duty_100", 32'(pif.duty), 32'd100);
      count_high(100, "hi_100");

      // Simultaneous presses, then a long held decrease
      bi_v = 1'b1; bd_v = 1'b1;
      cycle();
      bi_v = 1'b0; bd_v = 1'b0;
      run(5);
      check_eq("both_at_max", 32'(pif.at_max), 32'd1);
      bd_v = 1'b1;
      run(50);
      bd_v = 1'b0;
      run(110);
      check_eq("held_dec", 32'(pif.duty), 32'd90);
      press(1'b0, 4);
      run(110);
      check_eq("back_50", 32'(pif.duty), 32'd50);

      // Soft stop to OFF
      mr_v = 1'b0;
      wait_state(0, 800, "ramp_to_off");
      check_eq("off_duty", 32'(pif.duty), 32'd0);
      check_eq("off_ramping", 32'(pif.ramping), 32'd0);

      // Restart, then reverse mid-ramp-down at duty 20
      mr_v = 1'b1;
      wait_state(2, 800, "ramp_to_run2");
      mr_v = 1'b0;
      for (i = 0; i < 800 && m_eff != 20; i++) cycle();
      check_eq("reach_20", 32'(pif.duty), 32'd20);
      mr_v = 1'b1;
      for (i = 0; i < 200 && m_eff == 20; i++) cycle();
      check_eq("resume_30", 32'(pif.duty), 32'd30);
      wait_state(2, 800, "ramp_to_run3");

      // Asynchronous reset mid-ramp at cnt 37
      mr_v = 1'b0;
      for (i = 0; i < 300 && !(m_state == 3 && m_cnt == 37); i++) cycle();
      check_eq("reach_cnt37", 32'(i < 300), 32'd1);
      rst = 1'b1;
      model_reset();
      #1;
      check_eq("arst_out", 32'(dut_out()), 32'h000);
      rst_v = 1'b1;
      run(2);
      rst_v = 1'b0;
      press(1'b1, 4);
      check_eq("set_after_rst_90", 32'(pif.at_max), 32'd0);
      press(1'b1, 1);
      check_eq("set_after_rst_100", 32'(pif.at_max), 32'd1);
      run(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pwm_driver.md
Name: pwm_driver

Overview:
Downstream stage of the operator-interface FSM. Consumes `motor_running` and the raw speed buttons, and holds a duty setpoint that the buttons step up and down. Generates the actual fixed-period PWM waveform for the motor power stage. Applies a soft-start/soft-stop ramp so that the applied duty never jumps by more than STEP per PWM period.

Parameters:
- PERIOD, 100, PWM period in clk cycles; counter runs 0..PERIOD-1; must satisfy PERIOD <= 2^DUTY_W - 1.
- DUTY_W, 8, width of counter, setpoint and applied duty.
- STEP, 10, setpoint change per button press, and maximum applied-duty change per PWM period.
- DUTY_INIT, 50, setpoint after reset; must satisfy 0 <= DUTY_INIT <= PERIOD.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- motor_running  input  1  run request from the interface FSM, level-sensitive.
- btn_increase  input  1  speed-up button, level, already synchronous to clk.
- btn_decrease  input  1  speed-down button, level, already synchronous to clk.
- pwm_out  output  1  registered PWM drive to the power stage.
- duty  output  DUTY_W  currently applied duty (duty_eff).
- at_max  output  1  duty_set == PERIOD.
- at_min  output  1  duty_set == 0.
- ramping  output  1  FSM is in RAMP_UP or RAMP_DOWN.

Behaviour:
- Reset, asynchronous:
  - state = OFF, cnt = 0, duty_set = DUTY_INIT, duty_eff = 0, pwm_out = 0, edge registers = 0.
  - Consequently duty = 0, ramping = 0, and at_max/at_min reflect DUTY_INIT.
  - Reset asserted mid-ramp or mid-period aborts immediately to these values, with no ramp-down.
- Button edge detection:
  - Previous button levels are registered.
  - inc_pulse = rising edge of btn_increase; dec_pulse = rising edge of btn_decrease.
  - A button held high produces exactly one pulse.
- Setpoint update, active in every state:
  - inc_pulse only: duty_set = min(duty_set + STEP, PERIOD).
  - dec_pulse only: duty_set = max(duty_set - STEP, 0).
  - Both pulses in the same cycle: duty_set unchanged.
  - Arithmetic is done one bit wider than DUTY_W so the saturation never wraps.
- Counter:
  - In OFF, cnt is held at 0.
  - In all other states cnt increments each cycle and wraps PERIOD-1 -> 0.
  - pend (period end) = (cnt == PERIOD-1) and state != OFF.
- State machine, with transitions evaluated each cycle:
  - OFF:
    - motor_running = 1 -> RAMP_UP; cnt starts counting from 0 on the next cycle.
  - RAMP_UP:
    - motor_running = 0 -> RAMP_DOWN; this takes priority.
    - Otherwise, on pend: if duty_set <= duty_eff, set duty_eff = duty_set and go to RUN.
    - Otherwise, on pend: duty_eff = min(duty_eff + STEP, duty_set); go to RUN when the new value equals duty_set.
  - RUN:
    - motor_running = 0 -> RAMP_DOWN.
    - Otherwise, on pend: duty_eff = duty_set. Setpoint changes take effect only at period boundaries, with no ramp.
  - RAMP_DOWN:
    - motor_running = 1 -> RAMP_UP, continuing from the current duty_eff.
    - Otherwise, on pend: duty_eff = max(duty_eff - STEP, 0); when the new value is 0, go to OFF and clear cnt.
- duty_eff changes only on pend. Mid-period the applied duty is constant.
- PWM output:
  - pwm_out(n+1) = (state(n) != OFF) and (cnt(n) < duty_eff(n)). This is one cycle of latency.
  - duty_eff = 0 gives constant low; duty_eff = PERIOD gives constant high, with no glitch at the wrap.
- Flag outputs: at_max, at_min and ramping are combinational decodes of registers, with no latency.

Test Plan:
- Reset, then hold motor_running = 0 for 300 cycles -> pwm_out = 0, duty = 0, cnt stays at 0, at_max = 0, at_min = 0.
- Raise motor_running -> RAMP_UP. duty follows 0, 10, 20, 30, 40, 50, one step per 100-cycle period, then RUN with ramping = 0. In RUN, pwm_out is high for exactly 50 of every 100 cycles.
- In RUN at duty 50, press btn_increase 6 times, each held 5 cycles -> duty_set saturates at 100 and at_max = 1. duty becomes 100 at the next pend, and pwm_out then stays high continuously.
- Press both buttons in the same cycle -> duty_set unchanged. Hold btn_decrease for 50 cycles -> duty_set decreases by exactly 10.
- In RUN at 50, drop motor_running -> duty follows 40, 30, 20, 10, 0 at successive pends, then OFF with cnt = 0. Raise motor_running while duty is 20 -> RAMP_UP resumes from 20, not from 0.
- Assert rst mid-ramp with cnt = 37 -> the same cycle gives pwm_out = 0, duty = 0 and state OFF; duty_set returns to 50.
